// File: rtl/rf_wport_arbiter_pkg.sv
// rtl/rf_wport_arbiter_pkg.sv - shared widths, source codes and write-request struct for the RF write-port arbiter
package rf_wport_arbiter_pkg;

   localparam int RF_AW = 5;
   localparam int RF_DW = 32;

   localparam logic RF_SRC_PIPE = 1'b0;
   localparam logic RF_SRC_LONG = 1'b1;

   typedef struct packed {
      logic             we;
      logic [RF_AW-1:0] waddr;
      logic [RF_DW-1:0] wdata;
      logic [RF_DW-1:0] pc;
   } rf_wreq_t;

endpackage

// File: rtl/rf_hold_buf.sv
// rtl/rf_hold_buf.sv - one-entry long-result holding buffer with drain, flush and starvation counter
module rf_hold_buf
   import rf_wport_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [RF_AW-1:0] load_waddr,
   input  logic [RF_DW-1:0] load_wdata,
   input  logic [RF_DW-1:0] load_pc,
   input  logic             drain,
   input  logic             flush,
   output logic             h_valid,
   output logic [RF_AW-1:0] h_waddr,
   output logic [RF_DW-1:0] h_wdata,
   output logic [RF_DW-1:0] h_pc,
   output logic             h_starved
);

   rf_wreq_t   hold_q, hold_d;
   logic [3:0] starve_q, starve_d;

   // hold.we doubles as the valid bit; an r0 result is accepted but never becomes valid
   always_comb begin
      hold_d = hold_q;
      if (flush) begin
         hold_d.we = 1'b0;
      end else if (load) begin
         hold_d.we    = (load_waddr != '0);
         hold_d.waddr = load_waddr;
         hold_d.wdata = load_wdata;
         hold_d.pc    = load_pc;
      end else if (drain) begin
         hold_d.we = 1'b0;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (flush || drain || !hold_q.we) begin
         starve_d = '0;
      end else if (starve_q != 4'(STARVE_MAX)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_q   <= '0;
         starve_q <= '0;
      end else begin
         hold_q   <= hold_d;
         starve_q <= starve_d;
      end
   end

   assign h_valid   = hold_q.we;
   assign h_waddr   = hold_q.we ? hold_q.waddr : '0;
   assign h_wdata   = hold_q.wdata;
   assign h_pc      = hold_q.pc;
   assign h_starved = (starve_q == 4'(STARVE_MAX));

endmodule

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - RF write-port arbiter between WB and a long-latency unit; RF_ARB_PERF_EN adds perf counters
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int PERF_W     = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pipe_valid,
   input  logic             pipe_we,
   input  logic [RF_AW-1:0] pipe_waddr,
   input  logic [RF_DW-1:0] pipe_wdata,
   input  logic [RF_DW-1:0] pipe_pc,
   output logic             pipe_ready,
   input  logic             long_valid,
   input  logic [RF_AW-1:0] long_waddr,
   input  logic [RF_DW-1:0] long_wdata,
   input  logic [RF_DW-1:0] long_pc,
   output logic             long_ready,
   input  logic             flush,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_waddr,
   output logic [RF_DW-1:0] rf_wdata,
   output logic [RF_DW-1:0] rf_pc,
   output logic             rf_src,
   output logic             hold_valid,
   output logic [RF_AW-1:0] hold_waddr
`ifdef RF_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_pipe_stall,
   output logic [PERF_W-1:0] perf_hold_cycles
`endif
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15 || PERF_W < 1) begin : g_bad_param
      $error("rf_wport_arbiter: STARVE_MAX must be 1..15 and PERF_W >= 1");
   end

   logic             pipe_eff, grant_h, grant_p;
   logic             h_valid, h_starved;
   logic [RF_AW-1:0] h_waddr;
   logic [RF_DW-1:0] h_wdata, h_pc;
   rf_wreq_t         wreq;
   logic             src;

   rf_hold_buf #(.STARVE_MAX(STARVE_MAX)) u_hold (
      .clk        (clk),
      .resetn     (resetn),
      .load       (long_valid && long_ready),
      .load_waddr (long_waddr),
      .load_wdata (long_wdata),
      .load_pc    (long_pc),
      .drain      (grant_h),
      .flush      (flush),
      .h_valid    (h_valid),
      .h_waddr    (h_waddr),
      .h_wdata    (h_wdata),
      .h_pc       (h_pc),
      .h_starved  (h_starved)
   );

   // The buffered result is always older than WB, so a same-register clash goes to H first
   assign pipe_eff = pipe_valid && pipe_we && (pipe_waddr != '0);
   assign grant_h  = h_valid && !flush && (!pipe_eff || h_starved || (pipe_waddr == h_waddr));
   assign grant_p  = pipe_eff && !grant_h;

   assign pipe_ready = !pipe_eff || grant_p;
   assign long_ready = !flush && (!h_valid || grant_h);

   always_comb begin
      wreq = '0;
      src  = RF_SRC_PIPE;
      if (grant_h) begin
         wreq = '{we: 1'b1, waddr: h_waddr, wdata: h_wdata, pc: h_pc};
         src  = RF_SRC_LONG;
      end else if (grant_p) begin
         wreq = '{we: 1'b1, waddr: pipe_waddr, wdata: pipe_wdata, pc: pipe_pc};
      end
   end

   assign rf_we      = wreq.we;
   assign rf_waddr   = wreq.waddr;
   assign rf_wdata   = wreq.wdata;
   assign rf_pc      = wreq.pc;
   assign rf_src     = src;
   assign hold_valid = h_valid;
   assign hold_waddr = h_waddr;

`ifdef RF_ARB_PERF_EN
   logic [PERF_W-1:0] stall_q, stall_d, hold_cyc_q, hold_cyc_d;

   always_comb begin
      stall_d    = stall_q + PERF_W'(pipe_valid && !pipe_ready);
      hold_cyc_d = hold_cyc_q + PERF_W'(h_valid);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_q    <= '0;
         hold_cyc_q <= '0;
      end else begin
         stall_q    <= stall_d;
         hold_cyc_q <= hold_cyc_d;
      end
   end

   assign perf_pipe_stall  = stall_q;
   assign perf_hold_cycles = hold_cyc_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - scoreboard bench for rf_wport_arbiter against a queue-based reference model
module tb_rf_wport_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int PERF_W     = 32;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [31:0] rf_pc;
      logic        rf_src;
      logic        pipe_ready;
      logic        long_ready;
      logic        hold_valid;
      logic [4:0]  hold_waddr;
   } obs_t;

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      int          lcyc;
   } hent_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        pipe_valid, pipe_we, long_valid, flush;
   logic [4:0]  pipe_waddr, long_waddr;
   logic [31:0] pipe_wdata, pipe_pc, long_wdata, long_pc;
   logic        pipe_ready, long_ready, rf_we, rf_src, hold_valid;
   logic [4:0]  rf_waddr, hold_waddr;
   logic [31:0] rf_wdata, rf_pc;
`ifdef RF_ARB_PERF_EN
   logic [PERF_W-1:0] perf_pipe_stall, perf_hold_cycles;
`endif

   rf_wport_arbiter #(.STARVE_MAX(STARVE_MAX), .PERF_W(PERF_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .pipe_valid (pipe_valid),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .pipe_pc    (pipe_pc),
      .pipe_ready (pipe_ready),
      .long_valid (long_valid),
      .long_waddr (long_waddr),
      .long_wdata (long_wdata),
      .long_pc    (long_pc),
      .long_ready (long_ready),
      .flush      (flush),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .rf_pc      (rf_pc),
      .rf_src     (rf_src),
      .hold_valid (hold_valid),
      .hold_waddr (hold_waddr)
`ifdef RF_ARB_PERF_EN
      ,
      .perf_pipe_stall  (perf_pipe_stall),
      .perf_hold_cycles (perf_hold_cycles)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   obs_t        sb[$];
   hent_t       hq[$];
   logic [31:0] dut_rf [32];
   int          m_stall = 0;
   int          m_hold  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared against the live outputs
   initial begin
      for (int r = 0; r < 32; r++) dut_rf[r] = '0;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            obs_t e, a;
            e = sb.pop_front();
            a = '{rf_we, rf_waddr, rf_wdata, rf_pc, rf_src, pipe_ready, long_ready, hold_valid, hold_waddr};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL scoreboard: got we=%b a=%0d d=%h pc=%h src=%b pr=%b lr=%b hv=%b ha=%0d expected we=%b a=%0d d=%h pc=%h src=%b pr=%b lr=%b hv=%b ha=%0d",
                        a.rf_we, a.rf_waddr, a.rf_wdata, a.rf_pc, a.rf_src, a.pipe_ready, a.long_ready, a.hold_valid, a.hold_waddr,
                        e.rf_we, e.rf_waddr, e.rf_wdata, e.rf_pc, e.rf_src, e.pipe_ready, e.long_ready, e.hold_valid, e.hold_waddr);
            end
         end
         if (resetn && rf_we) dut_rf[rf_waddr] = rf_wdata;
      end
   end

   // One clock of stimulus: drive, predict from the buffered-entry queue, push, then advance the model
   task automatic step(input logic pv, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic fl);
      obs_t  e;
      hent_t h;
      logic  hv, peff, gh, gp;
      @(posedge clk);
      #1;
      pipe_valid = pv; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd; pipe_pc = $urandom;
      long_valid = lv; long_waddr = la; long_wdata = ld; long_pc = $urandom; flush = fl;

      hv   = (hq.size() != 0);
      h    = '{5'd0, 32'd0, 32'd0, 0};
      if (hv) h = hq[0];
      peff = pv && pwe && (pa != 5'd0);
      gh   = hv && !fl && (!peff || ((cyc - h.lcyc - 1) >= STARVE_MAX) || (pa == h.waddr));
      gp   = peff && !gh;
      e = '0;
      if (gh)      e = '{1'b1, h.waddr, h.wdata, h.pc, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
      else if (gp) e = '{1'b1, pa, pd, pipe_pc, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      e.pipe_ready = !peff || gp;
      e.long_ready = !fl && (!hv || gh);
      e.hold_valid = hv;
      e.hold_waddr = hv ? h.waddr : 5'd0;
      sb.push_back(e);

      if (pv && !e.pipe_ready) m_stall++;
      if (hv) m_hold++;
      if (fl) begin
         hq.delete();
      end else begin
         if (gh) void'(hq.pop_front());
         if (lv && e.long_ready && la != 5'd0) hq.push_back('{la, ld, long_pc, cyc});
      end
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      pipe_valid = 0; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0; pipe_pc = 0;
      long_valid = 0; long_waddr = 0; long_wdata = 0; long_pc = 0; flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_hold_valid", 32'(hold_valid), 32'd0);
      chk("reset_long_ready", 32'(long_ready), 32'd1);
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      resetn = 1'b1;

      step(1, 1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 0);
      chk("pipe_rf_we", 32'(rf_we), 32'd1);
      chk("pipe_rf_waddr", 32'(rf_waddr), 32'd5);
      chk("pipe_rf_src", 32'(rf_src), 32'd0);
      chk("pipe_ready", 32'(pipe_ready), 32'd1);

      step(1, 1, 5'd3, $urandom, 1, 5'd7, 32'hAA, 0);
      chk("starve_accept", 32'(long_ready), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         step(1, 1, 5'd3, $urandom, 0, 5'd0, 32'd0, 0);
         chk($sformatf("starve_hold_valid_%0d", k), 32'(hold_valid), (k <= 5) ? 32'd1 : 32'd0);
         chk($sformatf("starve_pipe_ready_%0d", k), 32'(pipe_ready), (k == 5) ? 32'd0 : 32'd1);
         if (k == 5) begin
            chk("starve_rf_waddr", 32'(rf_waddr), 32'd7);
            chk("starve_rf_src", 32'(rf_src), 32'd1);
            chk("starve_rf_wdata", rf_wdata, 32'hAA);
         end
      end

      step(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0);
      step(1, 1, 5'd9, 32'h22, 0, 5'd0, 32'd0, 0);
      chk("same_addr_stall", 32'(pipe_ready), 32'd0);
      chk("same_addr_h_first", rf_wdata, 32'h99);
      step(1, 1, 5'd9, 32'h22, 0, 5'd0, 32'd0, 0);
      chk("same_addr_resume", 32'(pipe_ready), 32'd1);
      chk("same_addr_young", rf_wdata, 32'h22);
      chk("same_addr_final_r9", dut_rf[9], 32'h22);

      step(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'h44, 0);
      step(1, 0, 5'd4, 32'h55, 0, 5'd0, 32'd0, 0);
      chk("nowe_rf_src", 32'(rf_src), 32'd1);
      chk("nowe_pipe_ready", 32'(pipe_ready), 32'd1);
      chk("nowe_rf_waddr", 32'(rf_waddr), 32'd4);
      idle();
      chk("nowe_drained", 32'(hold_valid), 32'd0);

      step(0, 0, 5'd0, 32'd0, 1, 5'd6, 32'h66, 0);
      step(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h77, 1);
      chk("flush_long_ready", 32'(long_ready), 32'd0);
      chk("flush_no_write", 32'(rf_we), 32'd0);
      idle();
      chk("flush_hold_cleared", 32'(hold_valid), 32'd0);
      chk("flush_r6_untouched", dut_rf[6], 32'd0);

      step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hEE, 0);
      chk("r0_accept", 32'(long_ready), 32'd1);
      chk("r0_not_held_now", 32'(hold_valid), 32'd0);
      idle();
      chk("r0_not_held", 32'(hold_valid), 32'd0);
      chk("r0_no_write", 32'(rf_we), 32'd0);

      step(1, 1, 5'd3, $urandom, 1, 5'd12, 32'hCC, 0);
      step(1, 1, 5'd3, $urandom, 0, 5'd0, 32'd0, 0);
      chk("midreset_held", 32'(hold_valid), 32'd1);
      chk("midreset_held_addr", 32'(hold_waddr), 32'd12);
      #1 resetn = 1'b0;
      #1;
      chk("midreset_hold_valid", 32'(hold_valid), 32'd0);
      chk("midreset_hold_waddr", 32'(hold_waddr), 32'd0);
      chk("midreset_long_ready", 32'(long_ready), 32'd1);
      #1 resetn = 1'b1;
      hq.delete();
      m_stall = 0;
      m_hold  = 0;

      for (int n = 0; n < 400; n++) begin
         logic [4:0] pa, la;
         pa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         la = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) != 0), pa, $urandom,
              1'($urandom_range(0, 9) < 4), la, $urandom, 1'($urandom_range(0, 15) == 0));
      end

      @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
`ifdef RF_ARB_PERF_EN
      chk("perf_pipe_stall", perf_pipe_stall, 32'(m_stall));
      chk("perf_hold_cycles", perf_hold_cycles, 32'(m_hold));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Owns the single register-file write port.
- Shares the port between the in-order pipeline writeback stage and a long-latency unit (mul/div) that completes out of band.
- Buffers one long-unit result, orders same-register writes, and prevents starvation of either source.
- Drives the WB stage's out_allow and supplies the final rf_we/rf_waddr/rf_wdata to the register file in ID.

Parameters:
- STARVE_MAX, 4, cycles a buffered long result may wait before it pre-empts the pipeline (1..15).
- PERF_W, 32, width of performance counters (used only with RF_ARB_PERF_EN).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pipe_valid  in  1  WB stage holds a valid instruction (WB_to_out_valid)
- pipe_we  in  1  WB instruction writes the RF
- pipe_waddr  in  5  WB destination register
- pipe_wdata  in  32  WB write data
- pipe_pc  in  32  WB pc
- pipe_ready  out  1  pipeline may retire this cycle (to WB out_allow)
- long_valid  in  1  long unit offers a result
- long_waddr  in  5  long-result destination
- long_wdata  in  32  long-result data
- long_pc  in  32  long-result pc
- long_ready  out  1  result accepted at this edge
- flush  in  1  exception/ertn flush; discards the buffered long result
- rf_we  out  1  RF write enable
- rf_waddr  out  5  RF write address
- rf_wdata  out  32  RF write data
- rf_pc  out  32  pc of the instruction writing this cycle
- rf_src  out  1  0 = pipeline, 1 = long buffer
- hold_valid  out  1  buffer occupied (for ID hazard detection)
- hold_waddr  out  5  buffered destination (for ID hazard detection)

Behaviour:
- Destination r0:
  - A pipeline write is effective only when pipe_we=1 and pipe_waddr≠0.
  - A long result with waddr=0 is accepted and then discarded; it never sets hold_valid.
- Holding buffer H (valid, waddr, wdata, pc):
  - long_ready = !flush && (!H.valid || grantH).
  - On long_valid && long_ready, H loads at the edge.
  - H.valid clears at the edge when grantH is set without a new load.
- Grant (combinational):
  - grantH = H.valid && !flush && (!pipe_eff || starve==STARVE_MAX || pipe_waddr==H.waddr), where pipe_eff = pipe_valid && effective write.
  - grantP = pipe_eff && !grantH.
- pipe_ready = !pipe_eff || grantP. A non-writing pipeline instruction retires in the same cycle that H writes.
- Same-address rule: H is always older than the current WB instruction, so H writes first. The pipeline stalls one cycle; then the younger value overwrites it.
- Outputs:
  - rf_we = grantH || grantP.
  - rf_waddr, rf_wdata, rf_pc and rf_src come from the granted source.
  - When rf_we=0, all these outputs are driven 0.
- Latency:
  - Pipeline write: 0 cycles, same cycle as pipe_valid.
  - Long result: written no earlier than the cycle after acceptance; at most STARVE_MAX+1 cycles after acceptance.
- Starvation counter starve (4 bits):
  - +1 each cycle that H.valid && !grantH, saturating at STARVE_MAX.
  - Cleared on grantH, on flush, or when H is empty.
- Flush:
  - At the next edge H.valid←0 and starve←0.
  - No grantH during the flush cycle.
  - The long unit is not accepted during flush.
  - The pipeline is unaffected; the WB stage handles its own flush.
- Reset (async, resetn=0): H.valid=0, starve=0, and all perf counters 0. Hence rf_we=0, hold_valid=0 and long_ready=1.
- hold_valid = H.valid; hold_waddr = H.waddr, forced to 0 when H is empty.

Optional Feature:
- RF_ARB_PERF_EN defined: adds outputs perf_pipe_stall (PERF_W) and perf_hold_cycles (PERF_W).
  - perf_pipe_stall counts cycles with pipe_valid && !pipe_ready.
  - perf_hold_cycles counts cycles with H.valid.
  - Both wrap on overflow and clear on reset.
- RF_ARB_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package: the RF address width (5), data width (32), the RF_SRC_PIPE=0 / RF_SRC_LONG=1 constants, and the struct for the write request {we, waddr, wdata, pc}.
- One sub-module, rf_hold_buf: the one-entry buffer with load, drain and flush, plus the starvation counter.
- Arbitration and output muxing stay in the top module.

Test Plan:
- After reset: pipe_valid=1, pipe_we=1, waddr=5, wdata=0x11 → same cycle rf_we=1, rf_waddr=5, rf_src=0, pipe_ready=1.
- Long result waddr=7, data=0xAA while the pipeline writes continuously to r3, STARVE_MAX=4:
  - hold_valid=1 from the next cycle.
  - pipe_ready=0 exactly on the 5th waiting cycle, with rf_waddr=7 and rf_src=1.
  - The pipeline resumes the cycle after.
- H holds r9; the pipeline writes r9=0x22 → the H value is written first (pipe_ready=0), then 0x22 next cycle; final RF r9=0x22.
- H holds r4; the pipeline instruction has pipe_we=0 → same cycle rf_src=1 and pipe_ready=1; H empties.
- H holds r6 and flush=1 → no write to r6, hold_valid=0 next cycle, long_ready=0 during the flush cycle.
- Long result waddr=0 → accepted with long_ready=1, hold_valid stays 0, rf_we never asserted for it; resetn pulsed low mid-hold → H cleared immediately.
